// File: rtl/dot_accum_pkg.sv
// Shared types and constants for the dot_accum burst accumulator.
package dot_accum_pkg;

    localparam int LEN_DEF   = 8;
    localparam int ACC_W_DEF = 24;
    localparam int PROD_W    = 16;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dot_accum_if.sv
// Product input / sum output handshake bundle for dot_accum.
// valid/ready: a transfer happens on a rising edge where both valid and ready are 1.
interface dot_accum_if
    import dot_accum_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
);
    logic [PROD_W-1:0] prod_i;
    logic              prod_valid_i;
    logic              prod_ready_o;
    logic              clr_i;
    logic [ACC_W-1:0]  sum_o;
    logic              sum_valid_o;
    logic              sum_ready_i;
    logic              ovf_o;
    state_t            state_dbg;

    modport slave (
        input  prod_i, prod_valid_i, clr_i, sum_ready_i,
        output prod_ready_o, sum_o, sum_valid_o, ovf_o, state_dbg
    );

    modport master (
        output prod_i, prod_valid_i, clr_i, sum_ready_i,
        input  prod_ready_o, sum_o, sum_valid_o, ovf_o, state_dbg
    );
endinterface

// File: rtl/dot_accum_sat_add.sv
// W-bit adder with carry out; wraps by default, clamps to all-ones when
// DOT_ACCUM_SAT_EN is defined.
module sat_add #(
    parameter int W = 24
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         carry
);
    logic [W:0] full;

    assign full  = {1'b0, a} + {1'b0, b};
    assign carry = full[W];

`ifdef DOT_ACCUM_SAT_EN
    // Once clamped, any nonzero addend carries again, so the value stays pinned.
    assign sum = carry ? {W{1'b1}} : full[W-1:0];
`else
    assign sum = full[W-1:0];
`endif
endmodule

// File: rtl/dot_accum.sv
// Accumulates LEN unsigned products per burst and holds the total until consumed.
// Optional saturation via DOT_ACCUM_SAT_EN (implemented in sat_add).
module dot_accum
    import dot_accum_pkg::*;
#(
    parameter int LEN   = LEN_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    dot_accum_if.slave  bus
);
    localparam int CNT_W = clog2(LEN + 1);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] add_sum;
    logic [ACC_W-1:0] sum_q;
    logic [CNT_W-1:0] cnt;
    logic             ovf_acc;
    logic             ovf_q;
    logic             carry;
    logic             last;

    assign last = (cnt == CNT_W'(LEN - 1));

    sat_add #(.W(ACC_W)) u_sat_add (
        .a     (acc),
        .b     (ACC_W'(bus.prod_i)),
        .sum   (add_sum),
        .carry (carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ACC;
            acc     <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (bus.clr_i) begin
            state   <= ACC;
            acc     <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (bus.prod_valid_i) begin
                        if (last) begin
                            // Final product goes straight to the result register.
                            sum_q <= add_sum;
                            ovf_q <= ovf_acc | carry;
                            state <= HOLD;
                        end else begin
                            acc     <= add_sum;
                            cnt     <= cnt + CNT_W'(1);
                            ovf_acc <= ovf_acc | carry;
                        end
                    end
                end
                HOLD: begin
                    if (bus.sum_ready_i) begin
                        state   <= ACC;
                        acc     <= '0;
                        cnt     <= '0;
                        ovf_acc <= 1'b0;
                        ovf_q   <= 1'b0;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

    assign bus.prod_ready_o = (state == ACC);
    assign bus.sum_valid_o  = (state == HOLD);
    assign bus.sum_o        = sum_q;
    assign bus.ovf_o        = ovf_q;
    assign bus.state_dbg    = state;
endmodule

// File: tb/tb_dot_accum.sv
// Bench for dot_accum: random and directed bursts against a plain-arithmetic model.
// Build with +define+DOT_ACCUM_SAT_EN to check the saturating variant.
module tb_dot_accum;
    import dot_accum_pkg::*;

    localparam int LEN    = 8;
    localparam int ACC_W  = 24;
    localparam int LEN2   = 2;
    localparam int ACC_W2 = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dot_accum_if #(.ACC_W(ACC_W))  bus ();
    dot_accum_if #(.ACC_W(ACC_W2)) bus2 ();

    dot_accum #(.LEN(LEN),  .ACC_W(ACC_W))  dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    dot_accum #(.LEN(LEN2), .ACC_W(ACC_W2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int n_checks = 0;
    int n_fail   = 0;

    logic [ACC_W:0] exp_q[$];
    int unsigned    burst[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: true sum of the burst, then wrap or clamp to w bits.
    task automatic model(input longint total, input int w, output logic [31:0] s, output logic o);
        longint lim;
        lim = longint'(1) << w;
        o = (total >= lim);
`ifdef DOT_ACCUM_SAT_EN
        s = o ? 32'(lim - 1) : 32'(total);
`else
        s = 32'(total % lim);
`endif
    endtask

    task automatic push_expected();
        longint      t;
        logic [31:0] s;
        logic        o;
        t = 0;
        foreach (burst[i]) t += burst[i];
        model(t, ACC_W, s, o);
        exp_q.push_back({o, s[ACC_W-1:0]});
    endtask

    // Monitor: every presented result must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n && bus.sum_valid_o) begin
            check("ready_in_hold", bus.prod_ready_o, 0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: sum_o=%0h with no expected entry", bus.sum_o);
            end else begin
                check("sum_o", bus.sum_o, exp_q[0][ACC_W-1:0]);
                check("ovf_o", bus.ovf_o, exp_q[0][ACC_W]);
                if (bus.sum_ready_i) void'(exp_q.pop_front());
            end
        end
    end

    // Called at posedge+1; returns at posedge+1, or at the result negedge after the last product.
    task automatic send(input logic [15:0] p, input int gap);
        bit is_last;
        if (gap > 0) begin
            bus.prod_valid_i = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
        bus.prod_i = p;
        bus.prod_valid_i = 1'b1;
        burst.push_back(int'(p));
        is_last = (burst.size() == LEN);
        if (is_last) push_expected();
        @(negedge clk);
        check("ready_in_acc", bus.prod_ready_o, 1);
        check("no_early_valid", bus.sum_valid_o, 0);
        @(posedge clk); #1;
        bus.prod_valid_i = 1'b0;
        if (is_last) begin
            burst.delete();
            @(negedge clk);
            check("result_latency", bus.sum_valid_o, 1);
        end
    endtask

    // Hold the result for 'hold' cycles while offering junk products, then consume it.
    task automatic drain(input int hold);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus.sum_valid_o;
        end
        check("result_arrived", seen, 1);
        if (!seen) begin @(posedge clk); #1; return; end
        bus.prod_valid_i = 1'b1;
        repeat (hold) begin
            bus.prod_i = 16'($urandom);
            @(posedge clk); #1;
        end
        bus.sum_ready_i = 1'b1;
        bus.prod_i = 16'($urandom);
        @(posedge clk); #1;
        bus.sum_ready_i = 1'b0;
        bus.prod_valid_i = 1'b0;
        @(negedge clk);
        check("valid_cleared", bus.sum_valid_o, 0);
        check("ready_restored", bus.prod_ready_o, 1);
        @(posedge clk); #1;
    endtask

    task automatic pair2(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] s;
        logic        o;
        model(longint'(a) + longint'(b), ACC_W2, s, o);
        bus2.prod_i = a;
        bus2.prod_valid_i = 1'b1;
        @(posedge clk); #1;
        bus2.prod_i = b;
        @(negedge clk);
        check("len2_no_early_valid", bus2.sum_valid_o, 0);
        @(posedge clk); #1;
        bus2.prod_valid_i = 1'b0;
        @(negedge clk);
        check("len2_valid", bus2.sum_valid_o, 1);
        check("len2_sum", bus2.sum_o, s[ACC_W2-1:0]);
        check("len2_ovf", bus2.ovf_o, o);
        @(posedge clk); #1;
        bus2.sum_ready_i = 1'b1;
        @(posedge clk); #1;
        bus2.sum_ready_i = 1'b0;
        @(negedge clk);
        check("len2_valid_cleared", bus2.sum_valid_o, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] p;
        bus.prod_i = '0;  bus.prod_valid_i = 1'b0;  bus.clr_i = 1'b0;  bus.sum_ready_i = 1'b0;
        bus2.prod_i = '0; bus2.prod_valid_i = 1'b0; bus2.clr_i = 1'b0; bus2.sum_ready_i = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", bus.prod_ready_o, 1);
        check("rst_valid", bus.sum_valid_o, 0);
        check("rst_sum", bus.sum_o, 0);
        check("rst_ovf", bus.ovf_o, 0);
        check("rst_state", bus.state_dbg, ACC);
        check("rst2_ready", bus2.prod_ready_o, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Contiguous full-scale products.
        for (int i = 0; i < LEN; i++) send(16'hFFFF, 0);
        drain(0);

        // 1..8 with idle gaps, held 5 cycles before consumption.
        for (int i = 1; i <= LEN; i++) send(16'(i), 2);
        drain(5);

        // Narrow instance: directed overflow case, then random pairs.
        pair2(16'hFFFF, 16'h0002);
        check("len2_sat_or_wrap_value", bus2.sum_o,
`ifdef DOT_ACCUM_SAT_EN
              16'hFFFF
`else
              16'h0001
`endif
        );
        for (int i = 0; i < 6; i++) pair2(16'($urandom), 16'($urandom_range(0, 3) == 0 ? 16'hFFFF : $urandom));

        // Abort a partial burst; the product on the clear cycle is dropped.
        for (int i = 0; i < 3; i++) send(16'd100, 0);
        bus.clr_i = 1'b1;
        bus.prod_valid_i = 1'b1;
        bus.prod_i = 16'd50;
        @(posedge clk); #1;
        bus.clr_i = 1'b0;
        bus.prod_valid_i = 1'b0;
        burst.delete();
        for (int i = 0; i < LEN; i++) send(16'd1, 0);
        drain(1);

        // Randomised bursts.
        for (int b = 0; b < 12; b++) begin
            for (int i = 0; i < LEN; i++) begin
                p = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
                send(p, $urandom_range(0, 3));
            end
            drain($urandom_range(0, 4));
        end

        // Asynchronous reset while a result is held.
        for (int i = 0; i < LEN; i++) send(16'd7, 0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", bus.sum_valid_o, 0);
        check("async_rst_sum", bus.sum_o, 0);
        check("async_rst_ready", bus.prod_ready_o, 1);
        check("async_rst_ovf", bus.ovf_o, 0);
        exp_q.delete();
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < LEN; i++) send(16'd2, 0);
        check("post_rst_sum_direct", bus.sum_o, 16);
        drain(0);

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dot_accum.md
DOT_ACCUM -- requirements
Module: dot_accum

Interface
REQ-001 Parameter LEN, default 8: products per burst; legal range 1..256.
REQ-002 Parameter ACC_W, default 24: accumulator and result width; legal range 16..32.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 prod_i  input  16  unsigned product, driven directly by the wallace multiplier op output.
REQ-006 prod_valid_i  input  1  prod_i is valid this cycle.
REQ-007 prod_ready_o  output  1  block accepts prod_i this cycle.
REQ-008 clr_i  input  1  synchronous burst abort.
REQ-009 sum_o  output  ACC_W  burst result.
REQ-010 sum_valid_o  output  1  sum_o and ovf_o are valid.
REQ-011 sum_ready_i  input  1  downstream consumes sum_o.
REQ-012 ovf_o  output  1  overflow occurred during the reported burst.

Function
REQ-013 A product SHALL be accepted only on a cycle with prod_valid_i=1 and prod_ready_o=1 (handshake).
REQ-014 The FSM SHALL have two states, ACC and HOLD; prod_ready_o=1 in ACC and 0 in HOLD; sum_valid_o=1 exactly in HOLD.
REQ-015 In ACC, each handshake SHALL add zero-extended prod_i to the accumulator and increment a burst counter.
REQ-016 The handshake that makes the count LEN SHALL load sum_o with the final total, set ovf_o, and enter HOLD on the next edge (latency 1 cycle from the last handshake).
REQ-017 Cycles without a handshake in ACC SHALL leave the accumulator and counter unchanged; gaps do not affect the result.
REQ-018 In HOLD, sum_o and ovf_o SHALL remain stable until sum_ready_i=1. On that edge the FSM SHALL return to ACC, and the accumulator, counter and burst overflow flag SHALL clear.
REQ-019 A product presented in the same cycle as sum_ready_i in HOLD SHALL NOT be accepted; minimum burst period is LEN+1 cycles.
REQ-020 Overflow SHALL be the carry out of the ACC_W-bit addition on any handshake of the burst. It is sticky for the burst and reported on ovf_o in HOLD.
REQ-021 When ACC_W >= 16+clog2(LEN), overflow SHALL be impossible and ovf_o SHALL stay 0.
REQ-022 clr_i=1 SHALL take priority over all handshakes in either state. On the next edge the accumulator, counter and overflow clear, and the FSM enters ACC with sum_valid_o=0. The product on that cycle is discarded.
REQ-023 For LEN=1, every handshake SHALL produce a result.

Reset
REQ-024 While rst_n=0, the state SHALL be ACC, the accumulator and counter 0, and outputs prod_ready_o=1, sum_o=0, sum_valid_o=0, ovf_o=0.
REQ-025 Reset asserted mid-burst or in HOLD SHALL discard all partial and pending results immediately, without waiting for a clock edge.

Configuration
REQ-026 With macro DOT_ACCUM_SAT_EN defined, an overflowing addition SHALL clamp the accumulator to all-ones, and later additions in the burst SHALL keep it at all-ones.
REQ-027 Without DOT_ACCUM_SAT_EN, accumulation SHALL wrap modulo 2^ACC_W.
REQ-028 The ovf_o behaviour SHALL be identical in both builds.

Structure
REQ-029 Package dot_accum_pkg SHALL hold the state typedef (ACC, HOLD), default LEN/ACC_W constants, and the counter-width function clog2.
REQ-030 One sub-module, sat_add, SHALL implement the ACC_W-bit add with carry out and the conditional clamp selected by DOT_ACCUM_SAT_EN. The FSM and counter stay in dot_accum.

Verification
REQ-031 Defaults, 8 contiguous products of 16'hFFFF -> sum_o=24'h07FFF8, ovf_o=0, sum_valid_o high on the cycle after the 8th handshake.
REQ-032 Defaults, products 1..8 with idle cycles between them -> sum_o=36. With sum_ready_i low for 5 cycles, sum_o is stable, prod_ready_o=0 and no products are consumed.
REQ-033 ACC_W=16, LEN=2, products 16'hFFFF then 16'h0002 -> wrap build: sum_o=16'h0001, ovf_o=1; DOT_ACCUM_SAT_EN build: sum_o=16'hFFFF, ovf_o=1.
REQ-034 Defaults, 3 products of 100, then clr_i for one cycle, then 8 products of 1 -> single result sum_o=8, ovf_o=0.
REQ-035 rst_n pulsed low mid-cycle while in HOLD -> sum_valid_o=0 and sum_o=0 before the next clock edge. The following full burst of 8 products of 2 gives sum_o=16.
